// File: rtl/rstation_append_unit.sv
// Reservation station for adder/multiplier/branch classes, NE entries each, CDB snooping.
// Latency: an appended entry or a CDB-woken operand becomes offerable one cycle after its edge.
// Backpressure: stall when the target class is full or func is illegal; FU dispatch gated by *_fu_rdy.
//
// Ports:
//   clk1, rst                 clock and asynchronous active-high reset
//   count, func, rd, rob_ind  append request from issue and the instruction fields
//   rs1b/rs1, rs2b/rs2        operand value, or ROB tag in the low TW bits when rsNb=1
//   cdb_valid/tag/data        common data bus broadcast, snooped by every entry
//   {add,mul,bch}_fu_rdy      functional unit accepts the offered entry this cycle
//   {add,mul,bch}_go/...      offered entry per class (combinational), zero when go=0
//   {add,mul,bch}_cnt         busy-entry count per class
//   stall                     append request cannot be accepted this cycle
module rstation_append_unit #(
  parameter int DW = 16,
  parameter int TW = 3,
  parameter int NE = 3
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          count,
  input  logic [3:0]    func,
  input  logic [3:0]    rd,
  input  logic [TW-1:0] rob_ind,
  input  logic          rs1b,
  input  logic          rs2b,
  input  logic [DW-1:0] rs1,
  input  logic [DW-1:0] rs2,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_tag,
  input  logic [DW-1:0] cdb_data,
  input  logic          add_fu_rdy,
  input  logic          mul_fu_rdy,
  input  logic          bch_fu_rdy,
  output logic          add_go,
  output logic [3:0]    add_func,
  output logic [DW-1:0] add_vj,
  output logic [DW-1:0] add_vk,
  output logic [TW-1:0] add_rob,
  output logic [3:0]    add_rd,
  output logic [1:0]    add_cnt,
  output logic          mul_go,
  output logic [3:0]    mul_func,
  output logic [DW-1:0] mul_vj,
  output logic [DW-1:0] mul_vk,
  output logic [TW-1:0] mul_rob,
  output logic [3:0]    mul_rd,
  output logic [1:0]    mul_cnt,
  output logic          bch_go,
  output logic [3:0]    bch_func,
  output logic [DW-1:0] bch_vj,
  output logic [DW-1:0] bch_vk,
  output logic [TW-1:0] bch_rob,
  output logic [3:0]    bch_rd,
  output logic [1:0]    bch_cnt,
  output logic          stall
);

  // Class index: 0 = adder, 1 = multiplier, 2 = branch.
  localparam int NC = 3;
  localparam logic [NE-1:0] ONE_E = NE'(1);

  // Entry storage
  logic [NE-1:0] busy    [NC];
  logic [NE-1:0] qj_pend [NC];
  logic [NE-1:0] qk_pend [NC];
  logic [3:0]    e_func  [NC][NE];
  logic [3:0]    e_rd    [NC][NE];
  logic [TW-1:0] e_rob   [NC][NE];
  logic [DW-1:0] e_vj    [NC][NE];
  logic [DW-1:0] e_vk    [NC][NE];
  logic [TW-1:0] e_qj    [NC][NE];
  logic [TW-1:0] e_qk    [NC][NE];

  // Per-class derived state
  logic [NE-1:0] ready    [NC];
  logic [NE-1:0] offer_oh [NC];
  logic [NE-1:0] free_oh  [NC];
  logic [NC-1:0] full;
  logic [NC-1:0] go;
  logic [NC-1:0] fu_rdy;

  // Offered-entry output mux
  logic [3:0]    o_func [NC];
  logic [3:0]    o_rd   [NC];
  logic [TW-1:0] o_rob  [NC];
  logic [DW-1:0] o_vj   [NC];
  logic [DW-1:0] o_vk   [NC];
  logic [1:0]    o_cnt  [NC];

  // Issue decode
  logic          func_ill;
  logic [NC-1:0] cls_oh;
  logic [NC-1:0] app_we;

  // Incoming operands after same-cycle CDB bypass
  logic          byp1;
  logic          byp2;
  logic [DW-1:0] in_vj;
  logic [DW-1:0] in_vk;
  logic          in_pj;
  logic          in_pk;

  assign fu_rdy = {bch_fu_rdy, mul_fu_rdy, add_fu_rdy};

  // 1xxx illegal, 01xx branch, 001x mul, 000x add.
  assign func_ill  = func[3];
  assign cls_oh[0] = ~func[3] & ~func[2] & ~func[1];
  assign cls_oh[1] = ~func[3] & ~func[2] &  func[1];
  assign cls_oh[2] = ~func[3] &  func[2];

  // Fullness comes from the registered busy map, so a slot that is being
  // dispatched this cycle still counts as occupied for the incoming request.
  assign stall  = count & (func_ill | (|(cls_oh & full)));
  assign app_we = {NC{count & ~func_ill}} & cls_oh & ~full;

  // A pending operand whose tag is on the CDB right now is captured directly,
  // otherwise it would miss its only broadcast.
  assign byp1  = rs1b & cdb_valid & (cdb_tag == rs1[TW-1:0]);
  assign byp2  = rs2b & cdb_valid & (cdb_tag == rs2[TW-1:0]);
  assign in_vj = byp1 ? cdb_data : rs1;
  assign in_vk = byp2 ? cdb_data : rs2;
  assign in_pj = rs1b & ~byp1;
  assign in_pk = rs2b & ~byp2;

  always_comb begin
    for (int c = 0; c < NC; c++) begin
      full[c]     = &busy[c];
      ready[c]    = busy[c] & ~qj_pend[c] & ~qk_pend[c];
      // x & (~x + 1) isolates the lowest set bit; same trick on ~busy for the free slot.
      offer_oh[c] = ready[c] & (~ready[c] + ONE_E);
      free_oh[c]  = ~busy[c] & (busy[c] + ONE_E);
      go[c]       = |ready[c];
    end
  end

  // Offered entry fields; all zero when nothing is ready since offer_oh is empty.
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      o_func[c] = '0;
      o_rd[c]   = '0;
      o_rob[c]  = '0;
      o_vj[c]   = '0;
      o_vk[c]   = '0;
      o_cnt[c]  = '0;
      for (int e = 0; e < NE; e++) begin
        if (offer_oh[c][e]) begin
          o_func[c] = e_func[c][e];
          o_rd[c]   = e_rd[c][e];
          o_rob[c]  = e_rob[c][e];
          o_vj[c]   = e_vj[c][e];
          o_vk[c]   = e_vk[c][e];
        end
        o_cnt[c] = o_cnt[c] + {1'b0, busy[c][e]};
      end
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        busy[c]    <= '0;
        qj_pend[c] <= '0;
        qk_pend[c] <= '0;
        for (int e = 0; e < NE; e++) begin
          e_func[c][e] <= '0;
          e_rd[c][e]   <= '0;
          e_rob[c][e]  <= '0;
          e_vj[c][e]   <= '0;
          e_vk[c][e]   <= '0;
          e_qj[c][e]   <= '0;
          e_qk[c][e]   <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        for (int e = 0; e < NE; e++) begin
          // CDB wakeup; both operands of one entry may match the same tag.
          if (busy[c][e] && qj_pend[c][e] && cdb_valid && (e_qj[c][e] == cdb_tag)) begin
            e_vj[c][e]    <= cdb_data;
            qj_pend[c][e] <= 1'b0;
          end
          if (busy[c][e] && qk_pend[c][e] && cdb_valid && (e_qk[c][e] == cdb_tag)) begin
            e_vk[c][e]    <= cdb_data;
            qk_pend[c][e] <= 1'b0;
          end
          // Dispatch frees the offered entry.
          if (offer_oh[c][e] && fu_rdy[c]) begin
            busy[c][e] <= 1'b0;
          end
          // Append targets a slot that was free before this edge, so it never
          // collides with the wakeup or dispatch updates above.
          if (app_we[c] && free_oh[c][e]) begin
            busy[c][e]    <= 1'b1;
            e_func[c][e]  <= func;
            e_rd[c][e]    <= rd;
            e_rob[c][e]   <= rob_ind;
            e_vj[c][e]    <= in_vj;
            e_vk[c][e]    <= in_vk;
            e_qj[c][e]    <= rs1[TW-1:0];
            e_qk[c][e]    <= rs2[TW-1:0];
            qj_pend[c][e] <= in_pj;
            qk_pend[c][e] <= in_pk;
          end
        end
      end
    end
  end

  assign add_go   = go[0];
  assign add_func = o_func[0];
  assign add_vj   = o_vj[0];
  assign add_vk   = o_vk[0];
  assign add_rob  = o_rob[0];
  assign add_rd   = o_rd[0];
  assign add_cnt  = o_cnt[0];

  assign mul_go   = go[1];
  assign mul_func = o_func[1];
  assign mul_vj   = o_vj[1];
  assign mul_vk   = o_vk[1];
  assign mul_rob  = o_rob[1];
  assign mul_rd   = o_rd[1];
  assign mul_cnt  = o_cnt[1];

  assign bch_go   = go[2];
  assign bch_func = o_func[2];
  assign bch_vj   = o_vj[2];
  assign bch_vk   = o_vk[2];
  assign bch_rob  = o_rob[2];
  assign bch_rd   = o_rd[2];
  assign bch_cnt  = o_cnt[2];

endmodule

// File: tb/tb_rstation_append_unit.sv
// Testbench for rstation_append_unit: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the reservation-station rules.
module tb_rstation_append_unit;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        count;
  logic [3:0]  func;
  logic [3:0]  rd;
  logic [2:0]  rob_ind;
  logic        rs1b, rs2b;
  logic [15:0] rs1, rs2;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        add_fu_rdy, mul_fu_rdy, bch_fu_rdy;

  logic        add_go, mul_go, bch_go;
  logic [3:0]  add_func, mul_func, bch_func;
  logic [15:0] add_vj, mul_vj, bch_vj, add_vk, mul_vk, bch_vk;
  logic [2:0]  add_rob, mul_rob, bch_rob;
  logic [3:0]  add_rd, mul_rd, bch_rd;
  logic [1:0]  add_cnt, mul_cnt, bch_cnt;
  logic        stall;

  always #5 clk1 = ~clk1;

  rstation_append_unit #(.DW(16), .TW(3), .NE(3)) dut (
    .clk1(clk1), .rst(rst), .count(count), .func(func), .rd(rd), .rob_ind(rob_ind),
    .rs1b(rs1b), .rs2b(rs2b), .rs1(rs1), .rs2(rs2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .add_fu_rdy(add_fu_rdy), .mul_fu_rdy(mul_fu_rdy), .bch_fu_rdy(bch_fu_rdy),
    .add_go(add_go), .add_func(add_func), .add_vj(add_vj), .add_vk(add_vk),
    .add_rob(add_rob), .add_rd(add_rd), .add_cnt(add_cnt),
    .mul_go(mul_go), .mul_func(mul_func), .mul_vj(mul_vj), .mul_vk(mul_vk),
    .mul_rob(mul_rob), .mul_rd(mul_rd), .mul_cnt(mul_cnt),
    .bch_go(bch_go), .bch_func(bch_func), .bch_vj(bch_vj), .bch_vk(bch_vk),
    .bch_rob(bch_rob), .bch_rd(bch_rd), .bch_cnt(bch_cnt),
    .stall(stall)
  );

  // Per-class views of the DUT outputs (0 add, 1 mul, 2 bch)
  logic        d_go   [3];
  logic [3:0]  d_func [3];
  logic [15:0] d_vj   [3];
  logic [15:0] d_vk   [3];
  logic [2:0]  d_rob  [3];
  logic [3:0]  d_rd   [3];
  logic [1:0]  d_cnt  [3];
  assign d_go[0] = add_go;   assign d_go[1] = mul_go;   assign d_go[2] = bch_go;
  assign d_func[0] = add_func; assign d_func[1] = mul_func; assign d_func[2] = bch_func;
  assign d_vj[0] = add_vj;   assign d_vj[1] = mul_vj;   assign d_vj[2] = bch_vj;
  assign d_vk[0] = add_vk;   assign d_vk[1] = mul_vk;   assign d_vk[2] = bch_vk;
  assign d_rob[0] = add_rob; assign d_rob[1] = mul_rob; assign d_rob[2] = bch_rob;
  assign d_rd[0] = add_rd;   assign d_rd[1] = mul_rd;   assign d_rd[2] = bch_rd;
  assign d_cnt[0] = add_cnt; assign d_cnt[1] = mul_cnt; assign d_cnt[2] = bch_cnt;

  // Reference model: each class is a table of three instruction records.
  typedef struct {
    bit        busy;
    bit [3:0]  func;
    bit [3:0]  rd;
    bit [2:0]  rob;
    bit [15:0] vj, vk;
    bit [2:0]  qj, qk;
    bit        wj, wk;   // waiting for a CDB tag
  } ent_t;
  ent_t m [3][3];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int class_of(input bit [3:0] f);
    if (f[3]) return -1;
    if (f[2]) return 2;
    if (f[1]) return 1;
    return 0;
  endfunction

  function automatic int occupancy(input int c);
    int n = 0;
    for (int e = 0; e < 3; e++) if (m[c][e].busy) n++;
    return n;
  endfunction

  function automatic int offered(input int c);
    for (int e = 0; e < 3; e++)
      if (m[c][e].busy && !m[c][e].wj && !m[c][e].wk) return e;
    return -1;
  endfunction

  function automatic bit exp_stall();
    int c = class_of(func);
    if (!count) return 1'b0;
    return (c < 0) || (occupancy(c) == 3);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++)
      for (int e = 0; e < 3; e++) m[c][e] = '{default: 0};
  endtask

  task automatic model_edge();
    int off [3];
    bit fu [3];
    int ac, slot;
    bit do_app;
    fu[0] = add_fu_rdy; fu[1] = mul_fu_rdy; fu[2] = bch_fu_rdy;
    for (int c = 0; c < 3; c++) off[c] = offered(c);
    ac = class_of(func);
    do_app = count && !exp_stall();
    slot = -1;
    if (do_app)
      for (int e = 2; e >= 0; e--) if (!m[ac][e].busy) slot = e;
    for (int c = 0; c < 3; c++) begin
      if (off[c] >= 0 && fu[c]) m[c][off[c]].busy = 0;
      for (int e = 0; e < 3; e++) begin
        if (cdb_valid && m[c][e].busy && m[c][e].wj && m[c][e].qj == cdb_tag) begin
          m[c][e].vj = cdb_data; m[c][e].wj = 0;
        end
        if (cdb_valid && m[c][e].busy && m[c][e].wk && m[c][e].qk == cdb_tag) begin
          m[c][e].vk = cdb_data; m[c][e].wk = 0;
        end
      end
    end
    if (do_app) begin
      ent_t n;
      n = '{default: 0};
      n.busy = 1; n.func = func; n.rd = rd; n.rob = rob_ind;
      if (!rs1b) n.vj = rs1;
      else if (cdb_valid && cdb_tag == rs1[2:0]) n.vj = cdb_data;
      else begin n.qj = rs1[2:0]; n.wj = 1; end
      if (!rs2b) n.vk = rs2;
      else if (cdb_valid && cdb_tag == rs2[2:0]) n.vk = cdb_data;
      else begin n.qk = rs2[2:0]; n.wk = 1; end
      m[ac][slot] = n;
    end
  endtask

  task automatic check_model();
    for (int c = 0; c < 3; c++) begin
      int o = offered(c);
      chk($sformatf("c%0d_go", c), 32'(d_go[c]), 32'(o >= 0));
      chk($sformatf("c%0d_cnt", c), 32'(d_cnt[c]), 32'(occupancy(c)));
      chk($sformatf("c%0d_func", c), 32'(d_func[c]), (o >= 0) ? 32'(m[c][o].func) : 32'd0);
      chk($sformatf("c%0d_vj", c), 32'(d_vj[c]), (o >= 0) ? 32'(m[c][o].vj) : 32'd0);
      chk($sformatf("c%0d_vk", c), 32'(d_vk[c]), (o >= 0) ? 32'(m[c][o].vk) : 32'd0);
      chk($sformatf("c%0d_rob", c), 32'(d_rob[c]), (o >= 0) ? 32'(m[c][o].rob) : 32'd0);
      chk($sformatf("c%0d_rd", c), 32'(d_rd[c]), (o >= 0) ? 32'(m[c][o].rd) : 32'd0);
    end
    chk("stall", 32'(stall), 32'(exp_stall()));
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 3 units later.
  task automatic sample();
    #3;
    check_model();
  endtask

  task automatic advance();
    @(posedge clk1);
    if (rst) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic set_idle();
    count = 0; func = 0; rd = 0; rob_ind = 0;
    rs1b = 0; rs2b = 0; rs1 = 0; rs2 = 0;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    add_fu_rdy = 0; mul_fu_rdy = 0; bch_fu_rdy = 0;
  endtask

  task automatic app(input logic [3:0] f, input logic [3:0] d, input logic [2:0] r,
                     input logic b1, input logic [15:0] s1, input logic b2, input logic [15:0] s2);
    count = 1; func = f; rd = d; rob_ind = r;
    rs1b = b1; rs1 = s1; rs2b = b2; rs2 = s2;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  initial begin
    rst = 1;
    set_idle();
    model_reset();
    repeat (2) @(posedge clk1);
    #1;
    rst = 0;

    // Reset state
    sample();
    chk("rst_add_go", 32'(add_go), 32'd0);
    chk("rst_bch_cnt", 32'(bch_cnt), 32'd0);
    advance();

    // Simple add append then dispatch
    app(4'b0000, 4'd4, 3'd2, 0, 16'd5, 0, 16'd7);
    cycle();
    set_idle();
    sample();
    chk("add_go", 32'(add_go), 32'd1);
    chk("add_vj", 32'(add_vj), 32'd5);
    chk("add_vk", 32'(add_vk), 32'd7);
    chk("add_rob", 32'(add_rob), 32'd2);
    chk("add_rd", 32'(add_rd), 32'd4);
    chk("add_cnt1", 32'(add_cnt), 32'd1);
    add_fu_rdy = 1;
    advance();
    set_idle();
    sample();
    chk("add_cnt0", 32'(add_cnt), 32'd0);
    chk("add_go0", 32'(add_go), 32'd0);
    advance();

    // Mul waiting on tag 3; unrelated tag 4 ignored
    app(4'b0010, 4'd1, 3'd5, 1, 16'd3, 0, 16'd2);
    cycle();
    set_idle();
    sample();
    chk("mul_wait", 32'(mul_go), 32'd0);
    cdb_valid = 1; cdb_tag = 3'd4; cdb_data = 16'h0055;
    advance();
    set_idle();
    sample();
    chk("mul_tag4", 32'(mul_go), 32'd0);
    cdb_valid = 1; cdb_tag = 3'd3; cdb_data = 16'h00AA;
    advance();
    set_idle();
    sample();
    chk("mul_wake", 32'(mul_go), 32'd1);
    chk("mul_vj", 32'(mul_vj), 32'h00AA);
    mul_fu_rdy = 1;
    advance();

    // Same-cycle CDB bypass on operand 2
    set_idle();
    app(4'b0001, 4'd9, 3'd1, 0, 16'd1, 1, 16'd6);
    cdb_valid = 1; cdb_tag = 3'd6; cdb_data = 16'd9;
    cycle();
    set_idle();
    sample();
    chk("byp_go", 32'(add_go), 32'd1);
    chk("byp_vk", 32'(add_vk), 32'd9);
    add_fu_rdy = 1;
    advance();

    // Fill branch class, then a fourth request stalls even with a dispatch
    set_idle();
    for (int i = 0; i < 3; i++) begin
      app(4'b0100, 4'(i), 3'(i), 0, 16'(i + 20), 0, 16'(i + 30));
      cycle();
    end
    app(4'b0100, 4'd7, 3'd7, 0, 16'd99, 0, 16'd98);
    sample();
    chk("bch_full_stall", 32'(stall), 32'd1);
    chk("bch_cnt3", 32'(bch_cnt), 32'd3);
    advance();
    sample();
    chk("bch_cnt_hold", 32'(bch_cnt), 32'd3);
    bch_fu_rdy = 1;
    sample();
    chk("bch_stall_disp", 32'(stall), 32'd1);
    advance();
    set_idle();
    sample();
    chk("bch_cnt2", 32'(bch_cnt), 32'd2);
    bch_fu_rdy = 1;
    advance();
    cycle();
    cycle();

    // Lowest-index priority between two ready adds, then async reset
    set_idle();
    app(4'b0000, 4'd1, 3'd3, 0, 16'd11, 0, 16'd0);
    cycle();
    app(4'b0000, 4'd2, 3'd4, 0, 16'd22, 0, 16'd0);
    cycle();
    set_idle();
    sample();
    chk("prio_slot0", 32'(add_vj), 32'd11);
    add_fu_rdy = 1;
    advance();
    add_fu_rdy = 0;
    sample();
    chk("prio_slot1", 32'(add_vj), 32'd22);
    app(4'b0011, 4'd3, 3'd6, 0, 16'd5, 0, 16'd6);
    advance();
    set_idle();
    #1;
    rst = 1;
    model_reset();
    #1;
    chk("arst_add_cnt", 32'(add_cnt), 32'd0);
    chk("arst_mul_cnt", 32'(mul_cnt), 32'd0);
    chk("arst_add_go", 32'(add_go), 32'd0);
    chk("arst_mul_go", 32'(mul_go), 32'd0);
    advance();
    rst = 0;
    cycle();

    // Illegal opcode
    app(4'b1000, 4'd5, 3'd5, 0, 16'd1, 0, 16'd1);
    sample();
    chk("illegal_stall", 32'(stall), 32'd1);
    advance();
    set_idle();
    sample();
    chk("illegal_add_cnt", 32'(add_cnt), 32'd0);
    advance();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      count      = ($urandom_range(0, 1) == 1);
      func       = {($urandom_range(0, 7) == 0), 3'($urandom)};
      rd         = 4'($urandom);
      rob_ind    = 3'($urandom);
      rs1b       = ($urandom_range(0, 2) == 0);
      rs2b       = ($urandom_range(0, 2) == 0);
      rs1        = 16'($urandom);
      rs2        = 16'($urandom);
      cdb_valid  = ($urandom_range(0, 1) == 1);
      cdb_tag    = 3'($urandom);
      cdb_data   = 16'($urandom);
      add_fu_rdy = ($urandom_range(0, 9) < 6);
      mul_fu_rdy = ($urandom_range(0, 9) < 6);
      bch_fu_rdy = ($urandom_range(0, 9) < 6);
      cycle();
    end

    set_idle();
    sample();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rstation_append_unit.md
Name: rstation_append_unit

Overview:
- Reservation-station block for the Tomasulo core, sitting between the issue stage and the functional units.
- Accepts one issued instruction per cycle and appends it to a free entry of its class: adder, multiplier or branch (3 entries each).
- Tracks operand readiness by snooping the common data bus (CDB).
- Per class, offers the lowest-index ready entry to that class's functional unit.

Parameters:
- DW, 16, operand/data width.
- TW, 3, ROB tag width (8-entry ROB).
- NE, 3, entries per class.

Ports:
- clk1  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- count  in  1  append request (issue stage has allocated a ROB slot).
- func  in  4  opcode: 0000/0001 add/sub, 0010/0011 mul, 01xx branch, 1xxx illegal.
- rd  in  4  destination register.
- rob_ind  in  TW  ROB index of the instruction.
- rs1b  in  1  1 = operand 1 pending; rs1 holds a tag.
- rs2b  in  1  1 = operand 2 pending; rs2 holds a tag.
- rs1  in  DW  operand 1 value, or tag in bits [TW-1:0] when rs1b=1.
- rs2  in  DW  operand 2, same encoding as rs1 with rs2b.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TW  ROB tag being broadcast.
- cdb_data  in  DW  broadcast result.
- {add,mul,bch}_fu_rdy  in  1 each  functional unit accepts a dispatch this cycle.
- {add,mul,bch}_go  out  1 each  a ready entry is offered (combinational).
- {add,mul,bch}_func  out  4 each  opcode of the offered entry.
- {add,mul,bch}_vj, _vk  out  DW each  operand values of the offered entry.
- {add,mul,bch}_rob  out  TW each  ROB index of the offered entry.
- {add,mul,bch}_rd  out  4 each  rd of the offered entry.
- {add,mul,bch}_cnt  out  2 each  busy-entry count, registered.
- stall  out  1  combinational: count=1 and the target class is full or func is illegal.

Behaviour:
- Entry state: busy, func, rd, rob, Vj, Qj, qj_pend, Vk, Qk, qk_pend.
- Reset (async): all busy=0, all pend=0, all cnt=0, all go=0. Other outputs are 0 while go=0.
- Append (count=1, legal func, class not full):
  - Write the lowest-index entry that is free at the start of the cycle; set busy.
  - Operand with rsNb=0: V=rsN, pend=0.
  - Operand with rsNb=1: Q=rsN[TW-1:0], pend=1.
  - Same-cycle bypass: if cdb_valid and cdb_tag equals the incoming tag, capture cdb_data and set pend=0.
- Dropped appends: a full class or illegal func writes nothing and raises stall. The issue stage must hold the request.
- CDB wakeup: every busy entry with pend=1 and Q==cdb_tag loads V=cdb_data and clears pend at the edge. Both operands of one entry may wake together.
- Readiness:
  - An entry is ready when busy=1 and both pend=0.
  - go = any ready entry in the class. The offered entry is the lowest-index ready one; outputs are driven combinationally from it.
- Dispatch: go and fu_rdy at an edge frees that entry (busy=0).
- Latency:
  - An entry appended at edge N can be offered after edge N, i.e. in cycle N+1.
  - An operand woken at edge N makes the entry ready in cycle N+1.
  - Zero-latency append-to-dispatch is not allowed.
- Simultaneous free and append in one class: the free-map used for the append is the one before the edge. A slot freed this cycle is not reused this cycle. stall is computed from the pre-edge count, so a class at 3 with a concurrent dispatch still stalls.
- cnt = number of busy entries, updated each edge, range 0..3.
- Classes are fully independent; each can dispatch in the same cycle.

Test Plan:
- Reset, then append add (func=0000, rs1b=rs2b=0, rs1=5, rs2=7, rob_ind=2, rd=4): next cycle add_go=1, vj=5, vk=7, rob=2, rd=4, add_cnt=1. With add_fu_rdy=1 → add_cnt=0 and add_go=0 next cycle.
- Append mul with rs1b=1, rs1=3: mul_go stays 0. Broadcast cdb_tag=3, cdb_data=0x00AA → mul_go=1 next cycle with vj=0x00AA. A broadcast of tag 4 has no effect.
- Append with rs2b=1, rs2=6 while cdb_valid=1, cdb_tag=6, cdb_data=9 in the same cycle → entry is ready next cycle with vk=9.
- Fill the branch class with 3 appends (func=0100, fu_rdy=0) → bch_cnt=3. A 4th append gives stall=1 and bch_cnt stays 3. The same 4th request with bch_fu_rdy=1 still stalls that cycle.
- Two ready add entries in slots 0 and 1 → slot 0 is offered first, then slot 1 after dispatch. Assert rst mid-operation → all cnt=0 and all go=0 immediately.
- func=1000 with count=1 → stall=1 and all counts unchanged.
